// File: rtl/mem_copy_engine.sv
// mem_copy_engine: block copy / block fill initiator that owns one port of a
// synchronous-write, asynchronous-read RW memory while an operation runs.
// Copy alternates READ (capture source word) and WRITE (store it at the
// destination), so it takes two cycles per word. Fill writes one word per cycle.
module mem_copy_engine #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  i_Clock,
  input  logic                  i_Reset,
  input  logic                  i_Start,
  input  logic                  i_Mode,
  input  logic [ADDR_WIDTH-1:0] i_SrcAddr,
  input  logic [ADDR_WIDTH-1:0] i_DstAddr,
  input  logic [ADDR_WIDTH-1:0] i_Length,
  input  logic [DATA_WIDTH-1:0] i_FillData,
  output logic                  o_Busy,
  output logic                  o_Done,
  output logic [ADDR_WIDTH-1:0] o_MemAddr,
  output logic                  o_MemWrEnable,
  output logic [DATA_WIDTH-1:0] o_MemWrData,
  input  logic [DATA_WIDTH-1:0] i_MemRdData
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Command fields that stay fixed for the whole operation.
  typedef struct packed {
    logic                  mode;  // 0 = copy, 1 = fill
    logic [DATA_WIDTH-1:0] fill;
  } cmd_t;

  state_t                state, state_nxt;
  cmd_t                  cmd;
  logic [ADDR_WIDTH-1:0] src_ptr;
  logic [ADDR_WIDTH-1:0] dst_ptr;
  logic [ADDR_WIDTH-1:0] remaining;
  logic [DATA_WIDTH-1:0] data_reg;

  logic accept;     // start taken this edge (only honoured in IDLE)
  logic last_word;  // current WRITE stores the final word

  assign accept    = (state == IDLE) && i_Start;
  assign last_word = (remaining == ADDR_WIDTH'(1));

  // State register; reset drops straight to IDLE so the write enable
  // (decoded from state) falls without waiting for a clock edge.
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) state <= IDLE;
    else         state <= state_nxt;
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (i_Start) begin
          if (i_Length == '0) state_nxt = DONE;
          else if (i_Mode)    state_nxt = WRITE;
          else                state_nxt = READ;
        end
      end
      READ:    state_nxt = WRITE;
      WRITE: begin
        if (last_word)     state_nxt = DONE;
        else if (cmd.mode) state_nxt = WRITE;
        else               state_nxt = READ;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Command latch: captured only on an accepted start so later input
  // changes (and starts while busy) cannot disturb a running operation.
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      cmd <= '0;
    end else if (accept) begin
      cmd.mode <= i_Mode;
      cmd.fill <= i_FillData;
    end
  end

  // Source pointer and read capture. Wraps modulo 2^ADDR_WIDTH.
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      src_ptr  <= '0;
      data_reg <= '0;
    end else if (accept) begin
      src_ptr  <= i_SrcAddr;
    end else if (state == READ) begin
      data_reg <= i_MemRdData;
      src_ptr  <= src_ptr + ADDR_WIDTH'(1);
    end
  end

  // Destination pointer and word counter, advanced once per write.
  // Overlapping regions fall out naturally: each read sees every earlier write.
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      dst_ptr   <= '0;
      remaining <= '0;
    end else if (accept) begin
      dst_ptr   <= i_DstAddr;
      remaining <= i_Length;
    end else if (state == WRITE) begin
      dst_ptr   <= dst_ptr + ADDR_WIDTH'(1);
      remaining <= remaining - ADDR_WIDTH'(1);
    end
  end

  // Output decode: memory port is driven to zero outside READ/WRITE, and
  // write enable only ever pairs with the destination pointer.
  always_comb begin
    o_Busy        = 1'b0;
    o_Done        = 1'b0;
    o_MemAddr     = '0;
    o_MemWrEnable = 1'b0;
    o_MemWrData   = '0;
    case (state)
      READ: begin
        o_Busy    = 1'b1;
        o_MemAddr = src_ptr;
      end
      WRITE: begin
        o_Busy        = 1'b1;
        o_MemAddr     = dst_ptr;
        o_MemWrEnable = 1'b1;
        o_MemWrData   = cmd.mode ? cmd.fill : data_reg;
      end
      DONE:    o_Done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_copy_engine.sv
// Bench for mem_copy_engine: behavioural RW memories, scoreboard of expected
// writes/reads filled when a command is driven and drained by bus monitors.
module tb_mem_copy_engine;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Main instance: 8-bit addresses, 256-word memory.
  logic        start, mode;
  logic [7:0]  src, dst, len;
  logic [31:0] fill;
  logic        busy, done, we;
  logic [7:0]  maddr;
  logic [31:0] wd, rd;
  logic [31:0] mem [0:255];
  logic        pre_we;
  logic [7:0]  pre_a;
  logic [31:0] pre_d;

  // Wrap instance: 4-bit addresses, 16-word memory.
  logic        start2, mode2;
  logic [3:0]  src2, dst2, len2;
  logic [31:0] fill2;
  logic        busy2, done2, we2;
  logic [3:0]  maddr2;
  logic [31:0] wd2, rd2;
  logic [31:0] mem2 [0:15];
  logic        pre_we2;
  logic [3:0]  pre_a2;
  logic [31:0] pre_d2;

  wr_t        exp_wr[$];
  wr_t        exp_wr2[$];
  logic [3:0] exp_rd2[$];

  int n_chk = 0, n_fail = 0;
  int busy_cnt = 0, wr_cnt = 0, done_cnt = 0;
  int d_at;

  mem_copy_engine #(.DATA_WIDTH(32), .ADDR_WIDTH(8)) u_dut (
    .i_Clock(clk), .i_Reset(rst), .i_Start(start), .i_Mode(mode),
    .i_SrcAddr(src), .i_DstAddr(dst), .i_Length(len), .i_FillData(fill),
    .o_Busy(busy), .o_Done(done), .o_MemAddr(maddr), .o_MemWrEnable(we),
    .o_MemWrData(wd), .i_MemRdData(rd)
  );

  mem_copy_engine #(.DATA_WIDTH(32), .ADDR_WIDTH(4)) u_dut_wrap (
    .i_Clock(clk), .i_Reset(rst), .i_Start(start2), .i_Mode(mode2),
    .i_SrcAddr(src2), .i_DstAddr(dst2), .i_Length(len2), .i_FillData(fill2),
    .o_Busy(busy2), .o_Done(done2), .o_MemAddr(maddr2), .o_MemWrEnable(we2),
    .o_MemWrData(wd2), .i_MemRdData(rd2)
  );

  // Memories: async read, sync write; preload port has priority.
  assign rd  = mem[maddr];
  assign rd2 = mem2[maddr2];
  always @(posedge clk) begin
    if (pre_we)  mem[pre_a] <= pre_d;
    else if (we) mem[maddr] <= wd;
  end
  always @(posedge clk) begin
    if (pre_we2)  mem2[pre_a2] <= pre_d2;
    else if (we2) mem2[maddr2] <= wd2;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Main bus monitor: counts activity and pops expected writes.
  always @(negedge clk) begin : mon_a
    wr_t e;
    if (!rst) begin
      if (busy) busy_cnt++;
      if (done) done_cnt++;
      if (we) begin
        wr_cnt++;
        check("wr_expected", exp_wr.size() > 0, 1);
        if (exp_wr.size() > 0) begin
          e = exp_wr.pop_front();
          check("wr_addr", {24'd0, maddr}, e.addr);
          check("wr_data", wd, e.data);
        end
      end
    end
  end

  // Wrap bus monitor: checks both the read and the write address streams.
  always @(negedge clk) begin : mon_b
    wr_t e;
    logic [3:0] ra;
    if (!rst) begin
      if (we2) begin
        check("wrap_wr_expected", exp_wr2.size() > 0, 1);
        if (exp_wr2.size() > 0) begin
          e = exp_wr2.pop_front();
          check("wrap_wr_addr", {28'd0, maddr2}, e.addr);
          check("wrap_wr_data", wd2, e.data);
        end
      end else if (busy2) begin
        check("wrap_rd_expected", exp_rd2.size() > 0, 1);
        if (exp_rd2.size() > 0) begin
          ra = exp_rd2.pop_front();
          check("wrap_rd_addr", maddr2, ra);
        end
      end
    end
  end

  task automatic load(input logic [7:0] a, input logic [31:0] d);
    @(negedge clk); pre_we = 1'b1; pre_a = a; pre_d = d;
    @(negedge clk); pre_we = 1'b0;
  endtask

  task automatic load2(input logic [3:0] a, input logic [31:0] d);
    @(negedge clk); pre_we2 = 1'b1; pre_a2 = a; pre_d2 = d;
    @(negedge clk); pre_we2 = 1'b0;
  endtask

  // Issue one command on the main instance; cycles are counted from the
  // first negedge after the start edge (index 0). A second start with
  // different arguments may be pulsed at cycle pulse_at.
  task automatic run(input logic m, input logic [7:0] s, input logic [7:0] d,
                     input logic [7:0] l, input logic [31:0] f,
                     input int pulse_at, output int done_at);
    @(negedge clk);
    busy_cnt = 0; wr_cnt = 0; done_cnt = 0;
    start = 1'b1; mode = m; src = s; dst = d; len = l; fill = f;
    @(posedge clk); #1;
    start = 1'b0; mode = ~m; src = 8'hAA; dst = 8'hB0; len = 8'h07; fill = 32'h5555_5555;
    done_at = -1;
    for (int c = 0; c < 64 && done_at < 0; c++) begin
      @(negedge clk);
      if (done) begin
        done_at = c;
        check("busy_low_at_done", busy, 0);
      end
      start = (c == pulse_at);
    end
    start = 1'b0;
    check("done_seen", done_at >= 0, 1);
    @(negedge clk);
    check("done_one_cycle", done, 0);
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; start = 1'b0; mode = 1'b0; src = '0; dst = '0; len = '0; fill = '0;
    start2 = 1'b0; mode2 = 1'b0; src2 = '0; dst2 = '0; len2 = '0; fill2 = '0;
    pre_we = 1'b0; pre_a = '0; pre_d = '0; pre_we2 = 1'b0; pre_a2 = '0; pre_d2 = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_we", we, 0);
    check("rst_addr", maddr, 0);
    check("rst_wdata", wd, 0);
    check("rst_wrap_busy", busy2, 0);
    rst = 1'b0;

    // Copy 0x10..0x13 -> 0x40..0x43.
    for (int i = 0; i < 4; i++) begin
      load(8'h10 + 8'(i), 32'hA000_00A0 + i);
      exp_wr.push_back('{32'h40 + i, 32'hA000_00A0 + i});
    end
    run(1'b0, 8'h10, 8'h40, 8'd4, 32'h0, -1, d_at);
    check("copy_done_at", d_at, 8);
    check("copy_busy_cycles", busy_cnt, 8);
    check("copy_wr_count", wr_cnt, 4);
    check("copy_done_count", done_cnt, 1);
    check("copy_queue", exp_wr.size(), 0);
    for (int i = 0; i < 4; i++) begin
      check("copy_src_kept", mem[8'h10 + 8'(i)], 32'hA000_00A0 + i);
      check("copy_dst", mem[8'h40 + 8'(i)], 32'hA000_00A0 + i);
    end

    // Fill 0x20..0x22 with a constant; neighbours untouched.
    load(8'h1F, 32'h1111_1F1F);
    load(8'h23, 32'h2323_2323);
    for (int i = 0; i < 3; i++) exp_wr.push_back('{32'h20 + i, 32'hDEAD_BEEF});
    run(1'b1, 8'h00, 8'h20, 8'd3, 32'hDEAD_BEEF, -1, d_at);
    check("fill_done_at", d_at, 3);
    check("fill_busy_cycles", busy_cnt, 3);
    check("fill_wr_count", wr_cnt, 3);
    check("fill_queue", exp_wr.size(), 0);
    check("fill_below", mem[8'h1F], 32'h1111_1F1F);
    check("fill_above", mem[8'h23], 32'h2323_2323);

    // Length 0: done right away, nothing else.
    run(1'b0, 8'h10, 8'h70, 8'd0, 32'h0, -1, d_at);
    check("len0_done_at", d_at, 0);
    check("len0_busy_cycles", busy_cnt, 0);
    check("len0_wr_count", wr_cnt, 0);
    check("len0_done_count", done_cnt, 1);

    // Overlap Dst = Src+1 with a stray start mid-operation.
    load(8'h05, 32'h5A5A_0005);
    load(8'h06, 32'h0000_0066);
    load(8'h07, 32'h0000_0077);
    load(8'h08, 32'h0000_0088);
    load(8'h09, 32'h0000_0099);
    for (int i = 0; i < 3; i++) exp_wr.push_back('{32'h06 + i, 32'h5A5A_0005});
    run(1'b0, 8'h05, 8'h06, 8'd3, 32'h0, 3, d_at);
    repeat (10) @(negedge clk);
    check("ovl_done_at", d_at, 6);
    check("ovl_done_count", done_cnt, 1);
    check("ovl_wr_count", wr_cnt, 3);
    check("ovl_queue", exp_wr.size(), 0);
    for (int i = 0; i < 3; i++) check("ovl_dst", mem[8'h06 + 8'(i)], 32'h5A5A_0005);
    check("ovl_src", mem[8'h05], 32'h5A5A_0005);
    check("ovl_after", mem[8'h09], 32'h0000_0099);

    // Reset during the third write of an 8-word fill.
    for (int i = 0; i < 3; i++) load(8'h50 + 8'(i), 32'hC0C0_0000 + i);
    for (int i = 0; i < 3; i++) exp_wr.push_back('{32'h50 + i, 32'hFEED_0001});
    @(negedge clk);
    busy_cnt = 0; wr_cnt = 0; done_cnt = 0;
    start = 1'b1; mode = 1'b1; dst = 8'h50; len = 8'd8; fill = 32'hFEED_0001;
    @(posedge clk); #1; start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst_async_we", we, 0);
    check("rst_async_busy", busy, 0);
    check("rst_async_addr", maddr, 0);
    repeat (3) @(negedge clk);
    check("rst_mid_wr_count", wr_cnt, 3);
    check("rst_mid_done_count", done_cnt, 0);
    check("rst_mid_queue", exp_wr.size(), 0);
    check("rst_mid_w0", mem[8'h50], 32'hFEED_0001);
    check("rst_mid_w1", mem[8'h51], 32'hFEED_0001);
    check("rst_mid_w2_untouched", mem[8'h52], 32'hC0C0_0002);
    rst = 1'b0;
    for (int i = 0; i < 2; i++) exp_wr.push_back('{32'h60 + i, 32'h0BAD_F00D});
    run(1'b1, 8'h00, 8'h60, 8'd2, 32'h0BAD_F00D, -1, d_at);
    check("post_rst_done_at", d_at, 2);
    check("post_rst_done_count", done_cnt, 1);
    check("post_rst_queue", exp_wr.size(), 0);

    // Address wrap on the 4-bit instance: reads E,F,0 then writes 2,3,4.
    load2(4'hE, 32'hB000_000E);
    load2(4'hF, 32'hB000_000F);
    load2(4'h0, 32'hB000_0000);
    exp_rd2.push_back(4'hE); exp_rd2.push_back(4'hF); exp_rd2.push_back(4'h0);
    exp_wr2.push_back('{32'h2, 32'hB000_000E});
    exp_wr2.push_back('{32'h3, 32'hB000_000F});
    exp_wr2.push_back('{32'h4, 32'hB000_0000});
    @(negedge clk);
    start2 = 1'b1; mode2 = 1'b0; src2 = 4'hE; dst2 = 4'h2; len2 = 4'd3;
    @(posedge clk); #1; start2 = 1'b0;
    d_at = -1;
    for (int c = 0; c < 32 && d_at < 0; c++) begin
      @(negedge clk);
      if (done2) d_at = c;
    end
    check("wrap_done_at", d_at, 6);
    check("wrap_rd_queue", exp_rd2.size(), 0);
    check("wrap_wr_queue", exp_wr2.size(), 0);
    @(negedge clk);
    check("wrap_mem2", mem2[4'h2], 32'hB000_000E);
    check("wrap_mem4", mem2[4'h4], 32'hB000_0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
